mem_stage: RTL

Memory-access stage between the EX/MEM pipeline register and the MEM/WB pipeline register. It performs data loads and stores over a simple request/acknowledge data bus and stalls the pipeline while an access is outstanding. It formats store data and byte enables, and extracts and extends load data. It selects the write-back result, flags misaligned or illegal accesses, and aborts accesses that are never acknowledged.

---
 rtl/mem_stage.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between EX/MEM and MEM/WB.
// Launches loads/stores on a req/ack data bus, stalls the pipeline while an
// access is outstanding, formats store lanes, extracts/extends load data,
// selects the write-back value, and aborts accesses that never get an ack.
//
// Handshake: dmem_req rises on the edge after an aligned access is seen in
// IDLE and the bus fields are held stable while it is high. The cycle in
// which dmem_ack is high completes the access: dmem_rdata is consumed in that
// same cycle and dmem_req falls on the following edge. An ack seen while no
// access is outstanding is ignored.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_reg_write,
    input  logic        mem_mem_write,
    input  logic        mem_mem_read,
    input  logic [1:0]  mem_mem_size,
    input  logic        mem_load_unsigned,
    input  logic [1:0]  mem_result_src,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_rs2_data,
    input  logic [4:0]  mem_rd_addr,
    input  logic [31:0] mem_pc_plus4,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd_addr,
    output logic [31:0] wb_result,
    output logic        stall,
    output logic        misalign_exc,
    output logic        bus_timeout,
    output logic        dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Counter value of the last BUSY cycle before an unanswered access aborts.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;

    logic        access;
    logic        misaligned;
    logic        aligned_access;
    logic [3:0]  be_fmt;
    logic [31:0] wdata_fmt;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext;
    logic        ack_hit;
    logic        timeout_hit;

    // Access decode, store lane formatting and load lane extraction.
    // The EX/MEM inputs are held by stall, so they stay valid through BUSY.
    always_comb begin
        access     = mem_mem_read | mem_mem_write;
        misaligned = ((mem_mem_size == 2'b01) && mem_alu_result[0])
                   || ((mem_mem_size == 2'b10) && (mem_alu_result[1:0] != 2'b00))
                   || (mem_mem_size == 2'b11);
        aligned_access = access & ~misaligned;

        be_fmt    = 4'b1111;
        wdata_fmt = mem_rs2_data;
        case (mem_mem_size)
            2'b00: begin
                be_fmt    = 4'b0001 << mem_alu_result[1:0];
                wdata_fmt = {4{mem_rs2_data[7:0]}};
            end
            2'b01: begin
                be_fmt    = 4'b0011 << {mem_alu_result[1], 1'b0};
                wdata_fmt = {2{mem_rs2_data[15:0]}};
            end
            default: begin
                be_fmt    = 4'b1111;
                wdata_fmt = mem_rs2_data;
            end
        endcase

        byte_lane = dmem_rdata[7:0];
        case (mem_alu_result[1:0])
            2'b00:   byte_lane = dmem_rdata[7:0];
            2'b01:   byte_lane = dmem_rdata[15:8];
            2'b10:   byte_lane = dmem_rdata[23:16];
            default: byte_lane = dmem_rdata[31:24];
        endcase
        half_lane = mem_alu_result[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

        case (mem_mem_size)
            2'b00:   load_ext = mem_load_unsigned ? {24'd0, byte_lane}
                                                  : {{24{byte_lane[7]}}, byte_lane};
            2'b01:   load_ext = mem_load_unsigned ? {16'd0, half_lane}
                                                  : {{16{half_lane[15]}}, half_lane};
            default: load_ext = dmem_rdata;
        endcase

        ack_hit     = (state_q == BUSY) && dmem_ack;
        timeout_hit = (state_q == BUSY) && !dmem_ack && (cnt_q == TIMEOUT_LAST);
    end

    // Next-state logic for the access FSM and its registered bus fields.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (aligned_access) begin
                    state_d = BUSY;
                    cnt_d   = 16'd0;
                    req_d   = 1'b1;
                    we_d    = mem_mem_write;
                    addr_d  = {mem_alu_result[31:2], 2'b00};
                    be_d    = be_fmt;
                    wdata_d = wdata_fmt;
                end
            end
            BUSY: begin
                if (ack_hit || timeout_hit) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and bus registers; reset drops the request immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
        end
    end

    // Pipeline-facing outputs: stall, exception flags and write-back select.
    always_comb begin
        if (state_q == IDLE) begin
            stall = rst_n & aligned_access;
        end else begin
            stall = ~(dmem_ack | timeout_hit);
        end
        misalign_exc = rst_n && (state_q == IDLE) && access && misaligned;
        bus_timeout  = timeout_hit;
        wb_reg_write = mem_reg_write & ~misalign_exc & ~timeout_hit;
        wb_rd_addr   = mem_rd_addr;
        case (mem_result_src)
            2'b01:   wb_result = (ack_hit && !we_q) ? load_ext : 32'd0;
            2'b10:   wb_result = mem_pc_plus4;
            default: wb_result = mem_alu_result;
        endcase
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;
    assign dbg_state  = state_q;

endmodule
